gsensor_reader: RTL and testbench
=================================

// Module: gsensor_reader
// PURPOSE
// Upstream stage of update_field: SPI master for the on-board ADXL345 accelerometer (4-wire, mode 3).
// After reset it configures the sensor, then reads X/Y acceleration periodically.
// Presents signed X/Y samples with a one-cycle valid strobe; these become the gravity input to the field update.
// PARAMETERS
// SCLK_HALF      10       clk cycles per SCLK half-period (50 MHz / 20 = 2.5 MHz SCLK); must be >= 2
// POWERUP_CYCLES 100_000  clk cycles to wait after reset release before the first SPI transfer
// CS_GAP         10       minimum clk cycles cs_n stays high between transactions
// SAMPLE_CYCLES  500_000  clk cycles spent in IDLE between the end of one read and the start of the next
// PORTS
// clk          in   1   system clock (MAX10_CLK1_50)
// rst_n        in   1   asynchronous, active-low reset
// gs_cs_n      out  1   SPI chip select, active low
// gs_sclk      out  1   SPI clock; idles high
// gs_sdi       out  1   MOSI; top level drives GSENSOR_SDI with this
// gs_sdo       in   1   MISO (from GSENSOR_SDO)
// accel_x      out  16  signed X sample, {DATAX1,DATAX0}
// accel_y      out  16  signed Y sample, {DATAY1,DATAY0}
// accel_valid  out  1   1-cycle pulse when accel_x/accel_y update
// cfg_done     out  1   high once all three config writes have completed; low again only on reset
// BEHAVIOUR
// - Reset: gs_cs_n=1, gs_sclk=1, gs_sdi=0, accel_x=0, accel_y=0, accel_valid=0, cfg_done=0, state=PWRUP, all counters 0.
// - Reset mid-transfer aborts the transfer immediately: cs_n high, sclk high; restart from PWRUP. No partial sample is published.
// - States: PWRUP -> W_FMT -> GAP -> W_RATE -> GAP -> W_PWR -> GAP -> IDLE -> RD_XY -> GAP -> IDLE ...
// - PWRUP: wait POWERUP_CYCLES, then start W_FMT.
// - Config writes are 16 bits: {R/W=0, MB=0, addr[5:0], data[7:0]}.
//   W_FMT: 0x31 <= 0x0B (full-res, +/-16 g). W_RATE: 0x2C <= 0x0A (100 Hz). W_PWR: 0x2D <= 0x08 (measure).
// - cfg_done rises in the cycle cs_n deasserts after W_PWR.
// - RD_XY is 40 bits: command byte 0xF2 ({R=1, MB=1, addr 0x32}), then 32 bits clocked in.
//   Received byte order: X0, X1, Y0, Y1.
// - Bit timing: cs_n falls; first MOSI bit (MSB) is valid before the first sclk fall.
//   sclk low SCLK_HALF cycles, then high SCLK_HALF cycles, per bit.
//   MOSI changes only on sclk falling edges; MISO is sampled on the clk cycle sclk rises.
//   After the last rising edge, sclk stays high and cs_n rises SCLK_HALF cycles later.
//   16-bit transfer: cs_n low for 16*2*SCLK_HALF + SCLK_HALF cycles.
// - Bits are shifted MSB first within each byte.
// - Publish: in the cycle after cs_n rises at the end of RD_XY:
//   accel_x <= {X1,X0}, accel_y <= {Y1,Y0}, accel_valid=1 for exactly one cycle.
//   Both outputs always update together; values are held between pulses.
// - GAP: cs_n high for CS_GAP cycles before the next state.
// - IDLE: count SAMPLE_CYCLES, then enter RD_XY. The counter runs only in IDLE, so reads never overlap.
//   Sample period = SAMPLE_CYCLES + CS_GAP + RD_XY duration.
// - Data is passed through as read, with no saturation or filtering.
//   In full-res mode the sensor already sign-extends to 16 bits.
// - gs_sdi=0 whenever cs_n is high. gs_sdo is ignored outside the RD_XY data phase.
// TESTING (bench: SCLK_HALF=2, POWERUP_CYCLES=50, CS_GAP=4, SAMPLE_CYCLES=100, ADXL345 SPI slave model)
// 1. Release reset -> cs_n stays high 50 cycles; the bench decodes three writes in order:
//    0x31=0x0B, 0x2C=0x0A, 0x2D=0x08; cfg_done=1 after the third.
// 2. Model returns X=0x0123, Y=0xFF9C -> command byte 0xF2; accel_x=16'h0123, accel_y=-100;
//    single-cycle accel_valid exactly 1 cycle after cs_n rises.
// 3. Timing check -> each 16-bit write holds cs_n low 66 cycles; each read 162 cycles; sclk high when idle;
//    MOSI never changes while sclk is high; cs_n high >= 4 cycles between transactions.
// 4. Back-to-back reads with new model data each time -> consecutive valid pulses 100+4+162 = 266 cycles apart;
//    outputs are stable between pulses.
// 5. Assert rst_n at bit 20 of RD_XY -> cs_n=1, sclk=1 and all outputs zero asynchronously;
//    no accel_valid; full config sequence repeats after release.
// 6. Model returns X=0x8000, Y=0x7FFF -> accel_x=-32768, accel_y=32767 (no saturation or sign errors).

Source files
------------

// File: rtl/gsensor_reader.sv
// gsensor_reader
// SPI master (4-wire, mode 3) for the ADXL345 accelerometer. After reset it
// waits for the sensor to power up, then writes three configuration
// registers. After that it reads X/Y every sample period and presents the
// signed result with a one-cycle valid strobe.
module gsensor_reader #(
   parameter int unsigned SCLK_HALF      = 10,       // clk cycles per SCLK half-period, >= 2
   parameter int unsigned POWERUP_CYCLES = 100_000,  // wait after reset before the first transfer
   parameter int unsigned CS_GAP         = 10,       // cs_n high time between transactions
   parameter int unsigned SAMPLE_CYCLES  = 500_000   // IDLE time between reads
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               gs_cs_n,
   output logic               gs_sclk,
   output logic               gs_sdi,
   input  logic               gs_sdo,
   output logic signed [15:0] accel_x,
   output logic signed [15:0] accel_y,
   output logic               accel_valid,
   output logic               cfg_done
);

   typedef enum logic [2:0] {
      PWRUP  = 3'd0,
      W_FMT  = 3'd1,
      W_RATE = 3'd2,
      W_PWR  = 3'd3,
      GAP    = 3'd4,
      IDLE   = 3'd5,
      RD_XY  = 3'd6
   } state_t;

   // A transfer is a leading sclk-high half, then two halves per bit.
   // Half 2*N is therefore the final high half of bit N.
   localparam logic [6:0] LAST_HALF_WR    = 7'd32;  // 16-bit write
   localparam logic [6:0] LAST_HALF_RD    = 7'd80;  // 40-bit read
   localparam logic [6:0] FIRST_DATA_RISE = 7'd18;  // rising edge of bit 9 (first data bit)

   state_t       r_state;
   state_t       r_next;       // where GAP goes when it expires
   logic [31:0]  r_cnt;        // shared wait / half-period counter
   logic [6:0]   r_half;       // half-period index within a transfer
   logic [38:0]  r_tx;         // MOSI bits still to be sent (MSB is next)
   logic [31:0]  r_rx;         // MISO data bytes X0,X1,Y0,Y1 (first byte in the MSBs)
   logic         r_pub;        // a completed read is waiting to be published

   logic         w_start;
   state_t       w_start_state;
   logic [39:0]  w_frame;
   logic         w_half_end;
   logic [6:0]   w_half_nxt;
   logic [6:0]   w_last_half;
   state_t       w_after;

   // Decide whether a transfer starts this cycle and which frame it sends.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      w_start       = 1'b0;
      w_start_state = RD_XY;
      case (r_state)
         PWRUP: if (r_cnt == POWERUP_CYCLES - 1) begin
            w_start       = 1'b1;
            w_start_state = W_FMT;
         end
         GAP: if ((r_cnt == CS_GAP - 1) && (r_next != IDLE)) begin
            w_start       = 1'b1;
            w_start_state = r_next;
         end
         IDLE: if (r_cnt == SAMPLE_CYCLES - 1) begin
            w_start       = 1'b1;
            w_start_state = RD_XY;
         end
         default: ;
      endcase

      // Writes are {R/W=0, MB=0, addr[5:0], data}; the read is {R=1, MB=1, 0x32}.
      case (w_start_state)
         W_FMT:   w_frame = {16'h310B, 24'h0};  // DATA_FORMAT: full-res, +/-16 g
         W_RATE:  w_frame = {16'h2C0A, 24'h0};  // BW_RATE: 100 Hz
         W_PWR:   w_frame = {16'h2D08, 24'h0};  // POWER_CTL: measure
         default: w_frame = {8'hF2, 32'h0};     // multi-byte read from DATAX0
      endcase

      w_half_end  = (r_cnt == SCLK_HALF - 1);
      w_half_nxt  = r_half + 7'd1;
      w_last_half = (r_state == RD_XY) ? LAST_HALF_RD : LAST_HALF_WR;

      case (r_state)
         W_FMT:   w_after = W_RATE;
         W_RATE:  w_after = W_PWR;
         default: w_after = IDLE;
      endcase
   end

   // Sequencer, SPI shifter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the shift registers are reset too; they are small and this keeps state fully defined.
         r_state     <= PWRUP;
         r_next      <= W_FMT;
         r_cnt       <= '0;
         r_half      <= '0;
         r_tx        <= '0;
         r_rx        <= '0;
         r_pub       <= 1'b0;
         gs_cs_n     <= 1'b1;
         gs_sclk     <= 1'b1;
         gs_sdi      <= 1'b0;
         accel_x     <= '0;
         accel_y     <= '0;
         accel_valid <= 1'b0;
         cfg_done    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         accel_valid <= 1'b0;
         if (w_start) begin
            // cs_n falls with the command MSB already on MOSI; sclk stays high for one half.
            r_state <= w_start_state;
            r_cnt   <= '0;
            r_half  <= '0;
            r_tx    <= w_frame[38:0];
            gs_sdi  <= w_frame[39];
            gs_cs_n <= 1'b0;
         end else begin
            case (r_state)
               PWRUP, IDLE: r_cnt <= r_cnt + 32'd1;
               GAP: begin
                  if (r_pub && (r_cnt == 32'd0)) begin
                     accel_x     <= {r_rx[23:16], r_rx[31:24]};
                     accel_y     <= {r_rx[7:0], r_rx[15:8]};
                     accel_valid <= 1'b1;
                     r_pub       <= 1'b0;
                  end
                  if (r_cnt == CS_GAP - 1) begin
                     r_state <= IDLE;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 32'd1;
                  end
               end
               default: begin
                  if (!w_half_end) begin
                     r_cnt <= r_cnt + 32'd1;
                  end else begin
                     r_cnt <= '0;
                     if (r_half == w_last_half) begin
                        // Last high half done: release the bus.
                        gs_cs_n <= 1'b1;
                        gs_sdi  <= 1'b0;
                        r_state <= GAP;
                        r_next  <= w_after;
                        if (r_state == W_PWR) cfg_done <= 1'b1;
                        if (r_state == RD_XY) r_pub <= 1'b1;
                     end else begin
                        r_half <= w_half_nxt;
                        if (w_half_nxt[0]) begin
                           // Falling edge; the first bit is already on MOSI.
                           gs_sclk <= 1'b0;
                           if (w_half_nxt >= 7'd3) begin
                              gs_sdi <= r_tx[38];
                              r_tx   <= {r_tx[37:0], 1'b0};
                           end
                        end else begin
                           // Rising edge; capture MISO only in the data phase of a read.
                           gs_sclk <= 1'b1;
                           if ((r_state == RD_XY) && (w_half_nxt >= FIRST_DATA_RISE))
                              r_rx <= {r_rx[30:0], gs_sdo};
                        end
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gsensor_reader.sv
// tb_gsensor_reader
// ADXL345 SPI slave model plus a scoreboard. Stimulus pushes the expected
// config writes and samples into queues; a monitor pops and compares them
// whenever the DUT finishes a write or strobes accel_valid.
module tb_gsensor_reader;

   typedef struct {
      int x;
      int y;
   } sample_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               gs_cs_n;
   logic               gs_sclk;
   logic               gs_sdi;
   logic               gs_sdo = 1'b0;
   logic signed [15:0] accel_x;
   logic signed [15:0] accel_y;
   logic               accel_valid;
   logic               cfg_done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [15:0] wr_q[$];
   sample_t     exp_q[$];

   // Slave model state
   logic [15:0] model_x = '0;
   logic [15:0] model_y = '0;
   int          sl_bits = 0;
   logic [39:0] sl_in   = '0;
   logic [31:0] sl_word = '0;
   logic        sl_cs_prev = 1'b1;

   // Monitor state
   int   valid_cnt = 0;
   int   sclk_idle_viol = 0;
   int   sdi_idle_viol = 0;
   int   mosi_viol = 0;
   int   stab_viol = 0;

   gsensor_reader #(
      .SCLK_HALF(2),
      .POWERUP_CYCLES(50),
      .CS_GAP(4),
      .SAMPLE_CYCLES(100)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .gs_cs_n(gs_cs_n),
      .gs_sclk(gs_sclk),
      .gs_sdi(gs_sdi),
      .gs_sdo(gs_sdo),
      .accel_x(accel_x),
      .accel_y(accel_y),
      .accel_valid(accel_valid),
      .cfg_done(cfg_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // ADXL345 slave: samples MOSI on sclk rise, drives MISO on sclk fall.
   always @(gs_cs_n or gs_sclk) begin
      if (!gs_cs_n) begin
         if (sl_cs_prev) begin
            sl_bits = 0;
            sl_in   = '0;
            sl_word = {model_x[7:0], model_x[15:8], model_y[7:0], model_y[15:8]};
            gs_sdo  = 1'b0;
         end else if (gs_sclk) begin
            sl_in   = {sl_in[38:0], gs_sdi};
            sl_bits = sl_bits + 1;
         end else begin
            if (sl_bits >= 8 && sl_bits < 40) begin
               int idx;
               idx    = 39 - sl_bits;
               gs_sdo = sl_word[idx];
            end else begin
               gs_sdo = 1'b0;
            end
         end
      end
      sl_cs_prev = gs_cs_n;
   end

   // Monitor: bus timing, decoded writes, and published samples.
   initial begin : monitor
      logic  prev_cs, prev_sclk, prev_sdi, prev_valid;
      int    low_len, high_len, rise_cyc, last_valid, wr_idx;
      logic  [15:0] held_x, held_y;
      logic  [15:0] exp_wr;
      sample_t es;
      prev_cs = 1'b1; prev_sclk = 1'b1; prev_sdi = 1'b0; prev_valid = 1'b0;
      low_len = 0; high_len = 0; rise_cyc = -10; last_valid = -1; wr_idx = 0;
      held_x = '0; held_y = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_cs = 1'b1; prev_sclk = 1'b1; prev_sdi = 1'b0; prev_valid = 1'b0;
            low_len = 0; high_len = 0; rise_cyc = -10; last_valid = -1; wr_idx = 0;
            held_x = '0; held_y = '0;
         end else begin
            if (gs_cs_n) begin
               if (!prev_cs) begin
                  rise_cyc = cyc;
                  if (sl_bits == 16) begin
                     wr_idx++;
                     check("write_cs_low_cycles", low_len, 66);
                     if (wr_q.size() == 0) begin
                        check("unexpected_write", sl_in[15:0], -1);
                     end else begin
                        exp_wr = wr_q.pop_front();
                        check("write_word", sl_in[15:0], exp_wr);
                     end
                     check("cfg_done_at_write", cfg_done, (wr_idx == 3));
                  end else if (sl_bits == 40) begin
                     check("read_cs_low_cycles", low_len, 162);
                     check("read_cmd_byte", sl_in[39:32], 8'hF2);
                  end else begin
                     check("transfer_bit_count", sl_bits, 40);
                  end
                  high_len = 0;
               end
               high_len++;
               if (!gs_sclk) sclk_idle_viol++;
               if (gs_sdi)   sdi_idle_viol++;
            end else begin
               if (prev_cs) begin
                  check("cs_gap_at_least_4", (high_len >= 4), 1);
                  low_len = 0;
               end
               low_len++;
               if (!prev_cs && prev_sclk && gs_sclk && (gs_sdi !== prev_sdi)) mosi_viol++;
            end

            if (accel_valid) begin
               valid_cnt++;
               check("valid_one_cycle_after_cs_rise", cyc - rise_cyc, 1);
               check("valid_single_cycle", prev_valid, 0);
               check("cfg_done_during_reads", cfg_done, 1);
               if (last_valid >= 0) check("valid_period", cyc - last_valid, 266);
               last_valid = cyc;
               if (exp_q.size() == 0) begin
                  check("unexpected_valid", valid_cnt, -1);
               end else begin
                  es = exp_q.pop_front();
                  check("accel_x", longint'(accel_x), es.x);
                  check("accel_y", longint'(accel_y), es.y);
               end
               held_x = accel_x;
               held_y = accel_y;
            end else if ((accel_x !== held_x) || (accel_y !== held_y)) begin
               stab_viol++;
               held_x = accel_x;
               held_y = accel_y;
            end
            prev_valid = accel_valid;
         end
         prev_cs   = gs_cs_n;
         prev_sclk = gs_sclk;
         prev_sdi  = gs_sdi;
      end
   end

   task automatic push_config();
      wr_q.push_back(16'h310B);
      wr_q.push_back(16'h2C0A);
      wr_q.push_back(16'h2D08);
   endtask

   task automatic set_sample(input logic [15:0] rx, input logic [15:0] ry,
                             input int ex, input int ey);
      sample_t s;
      model_x = rx;
      model_y = ry;
      s.x = ex;
      s.y = ey;
      exp_q.push_back(s);
   endtask

   task automatic release_and_config(input string tag);
      int t_rel;
      @(posedge clk);
      #1 rst_n = 1'b1;
      t_rel = cyc;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!gs_cs_n) break;
      end
      check({tag, "_powerup_cycles"}, cyc - t_rel, 50);
      for (int i = 0; i < 1000; i++) begin
         if (cfg_done) break;
         @(negedge clk);
      end
      check({tag, "_cfg_done"}, cfg_done, 1);
      check({tag, "_writes_all_seen"}, wr_q.size(), 0);
   endtask

   task automatic wait_valid(input int n);
      for (int i = 0; i < 1500; i++) begin
         if (valid_cnt >= n) break;
         @(negedge clk);
      end
      check("valid_arrived", (valid_cnt >= n), 1);
   endtask

   // Directed stimulus.
   initial begin : stim
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs_n", gs_cs_n, 1);
      check("rst_sclk", gs_sclk, 1);
      check("rst_sdi", gs_sdi, 0);
      check("rst_accel_x", accel_x, 0);
      check("rst_accel_y", accel_y, 0);
      check("rst_valid", accel_valid, 0);
      check("rst_cfg_done", cfg_done, 0);

      push_config();
      set_sample(16'h0123, 16'hFF9C, 291, -100);
      release_and_config("boot");
      wait_valid(1);

      set_sample(16'h0ABC, 16'hFFFE, 2748, -2);
      wait_valid(2);
      set_sample(16'hFFFF, 16'h0001, -1, 1);
      wait_valid(3);
      set_sample(16'h1234, 16'hEDCB, 4660, -4661);
      wait_valid(4);

      // Abort a read at bit 20; this sample must never be published.
      model_x = 16'h5555;
      model_y = 16'h2AAA;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (!gs_cs_n && sl_bits == 20) break;
      end
      check("abort_reached_bit20", sl_bits, 20);
      #1 rst_n = 1'b0;
      #1;
      check("abort_cs_n", gs_cs_n, 1);
      check("abort_sclk", gs_sclk, 1);
      check("abort_sdi", gs_sdi, 0);
      check("abort_accel_x", accel_x, 0);
      check("abort_accel_y", accel_y, 0);
      check("abort_valid", accel_valid, 0);
      check("abort_cfg_done", cfg_done, 0);
      repeat (5) @(posedge clk);

      push_config();
      set_sample(16'h8000, 16'h7FFF, -32768, 32767);
      release_and_config("reboot");
      wait_valid(5);
      repeat (20) @(negedge clk);

      check("valid_count", valid_cnt, 5);
      check("samples_all_seen", exp_q.size(), 0);
      check("sclk_high_when_idle", sclk_idle_viol, 0);
      check("sdi_low_when_idle", sdi_idle_viol, 0);
      check("mosi_stable_while_sclk_high", mosi_viol, 0);
      check("outputs_stable_between_pulses", stab_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule
